apb_irq_ctrl: RTL and testbench
===============================

Name: apb_irq_ctrl

Overview:
- APB slave interrupt controller sitting directly downstream of system_timer and other peripherals.
- Collects up to NUM_SRC interrupt lines (system_timer INTR wired to src 0) and latches them as pending.
- Arbitrates them by fixed priority, where the lowest index wins, and drives one interrupt line to the CPU.
- Uses a claim/complete handshake so only one source is in service at a time.

Parameters:
- DATA_WIDTH, 32, APB data width.
- NUM_SRC, 8, number of interrupt sources; range 1..31.
- ID_WIDTH, 5, width of source ID field; ID value = source index + 1, 0 = none.

Ports:
- PCLK  in  1  system clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable (access phase).
- PWRITE  in  1  APB write.
- PADDR  in  5  APB byte address.
- PWDATA  in  DATA_WIDTH  APB write data.
- PRDATA  out  DATA_WIDTH  APB read data.
- PREADY  out  1  tied 1; no wait states.
- irq_src  in  NUM_SRC  raw interrupt inputs, e.g. system_timer INTR.
- irq_o  out  1  interrupt request to CPU.

Behaviour:
- Clock and reset: one clock (PCLK); reset PRESETn is asynchronous, active-low.
- Reset values: ENABLE=0, TYPE=0 (all level), pending=0, busy=0, active_id=0, sampled inputs=0, PRDATA=0, irq_o=0.
- Register map, APB access = PSEL&PENABLE, all upper bits read 0:
  - 0x00 PENDING RO [NUM_SRC-1:0].
  - 0x04 ENABLE RW.
  - 0x08 TYPE RW (1=edge, 0=level).
  - 0x0C CLAIM: read = claim; write = complete.
  - 0x10 ACTIVE RO: {busy at bit 8, active_id[ID_WIDTH-1:0]}.
  - Unmapped addresses read 0; writes to them are ignored.
- PRDATA is combinational and is 0 outside a read access.
- Input stage: irq_src is registered once (s1). Edge detect = s1 & ~s1_d.
- Level source: pending[i] <= s1[i] every cycle.
- Edge source: pending[i] set on a rising edge; cleared only by claim.
- Latency: irq_src rising at edge N -> s1 at N -> pending at N+1 -> irq_o high after N+1 (combinational from registers). This is 2 cycles without the Optional Feature.
- irq_o = !busy && |(pending & ENABLE).
- Claim: read of 0x0C during the access phase.
  - If !busy and a candidate exists (lowest i with pending & ENABLE): PRDATA=i+1 that cycle; at the clock edge busy<=1, active_id<=i+1; if source i is edge type, pending[i]<=0.
  - If busy or no candidate: PRDATA=0 and no state change.
- Complete: write to 0x0C with PWDATA[ID_WIDTH-1:0]==active_id while busy -> busy<=0, active_id<=0. Mismatched ID, or write while idle, is ignored.
- Simultaneous claim of edge source i and a new edge on i in the same cycle: pending[i] stays 1 (set wins).
- Level source still high after complete -> irq_o reasserts the next cycle.
- Writing ENABLE or TYPE does not alter pending.
- Disabling the active source does not clear busy.
- TYPE change takes effect for edges detected from the next cycle.
- Reset mid-service: everything returns to reset values immediately; irq_o drops asynchronously.

Optional Feature:
- Macro: IRQC_SYNC_EN.
- Defined: a 2-FF synchronizer precedes s1, adding 2 cycles; irq_src rising at edge N gives pending at N+3.
- Undefined: single sample stage as described above.
- Register map and handshake are identical in both cases.

Decomposition:
- Shared package apb_irq_ctrl_pkg holds:
  - address localparams (ADDR_PENDING, ADDR_ENABLE, ADDR_TYPE, ADDR_CLAIM, ADDR_ACTIVE);
  - ACTIVE busy bit position (8);
  - ID_NONE = 0.
- Sub-module irq_prio_enc: combinational find-first-set over NUM_SRC bits, outputs valid plus ID (index+1).

Test Plan:
- Reset, then ENABLE=0x01, TYPE=0, irq_src[0]=1 -> irq_o high 2 cycles later; CLAIM read returns 1; irq_o low; ACTIVE=0x101.
- Pending src 2 and src 5, both enabled, edge type -> CLAIM returns 3; complete with 3; next CLAIM returns 6; PENDING=0 afterwards.
- Busy with ID 1, write complete with 4 -> ignored, ACTIVE still 0x101; write 1 -> ACTIVE=0, irq_o reasserts if src 0 is still high (level).
- Edge source 1 pulse arriving in the same cycle as its claim -> PENDING[1] remains 1 after the claim.
- CLAIM read with nothing pending -> returns 0, ACTIVE unchanged. ENABLE=0 with src pending -> irq_o=0, and PENDING still shows the bit.
- Assert PRESETn low while busy -> irq_o, PENDING and ACTIVE read 0 after release. With IRQC_SYNC_EN defined, input-to-irq_o latency is 4 cycles.

Source files
------------

// File: rtl/apb_irq_ctrl_pkg.sv
// Shared constants for the APB interrupt controller: register offsets,
// ACTIVE register layout and the "no source" ID value.
package apb_irq_ctrl_pkg;

    localparam logic [4:0] ADDR_PENDING = 5'h00;
    localparam logic [4:0] ADDR_ENABLE  = 5'h04;
    localparam logic [4:0] ADDR_TYPE    = 5'h08;
    localparam logic [4:0] ADDR_CLAIM   = 5'h0C;
    localparam logic [4:0] ADDR_ACTIVE  = 5'h10;

    localparam int ACTIVE_BUSY_BIT = 8;
    localparam int ID_NONE         = 0;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority find-first-set: lowest set request index wins and is
// reported as index+1, so an ID of 0 means no request.
module irq_prio_enc
    import apb_irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC  = 8,
    parameter int ID_WIDTH = 5
) (
    input  logic [NUM_SRC-1:0]  i_req,
    output logic                o_valid,
    output logic [ID_WIDTH-1:0] o_id
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        o_valid = 1'b0;
        o_id    = ID_WIDTH'(ID_NONE);
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_id    = ID_WIDTH'(i + 1);
            end
        end
    end

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: latches level/edge sources as pending, arbitrates by
// lowest index, claim/complete handshake. Define IRQC_SYNC_EN for a 2-FF input synchronizer.
module apb_irq_ctrl
    import apb_irq_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 8,
    parameter int ID_WIDTH   = 5
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [4:0]            PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    input  logic [NUM_SRC-1:0]    irq_src,
    output logic                  irq_o
);

    logic [NUM_SRC-1:0]  r_s1;
    logic [NUM_SRC-1:0]  r_s1_d;
    logic [NUM_SRC-1:0]  r_pending;
    logic [NUM_SRC-1:0]  r_enable;
    logic [NUM_SRC-1:0]  r_type;
    logic                r_busy;
    logic [ID_WIDTH-1:0] r_active_id;

    logic [NUM_SRC-1:0]  w_s1_in;
    logic [NUM_SRC-1:0]  w_edge;
    logic [NUM_SRC-1:0]  w_claim_clr;
    logic [NUM_SRC-1:0]  w_pend_next;
    logic                w_cand_vld;
    logic [ID_WIDTH-1:0] w_cand_id;
    logic                w_rd;
    logic                w_wr;
    logic                w_claim;
    logic                w_complete;
    logic                w_unused;

`ifdef IRQC_SYNC_EN
    logic [NUM_SRC-1:0]  r_sync0;
    logic [NUM_SRC-1:0]  r_sync1;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
        end else begin
            r_sync0 <= irq_src;
            r_sync1 <= r_sync0;
        end
    end

    assign w_s1_in = r_sync1;
`else
    assign w_s1_in = irq_src;
`endif

    assign PREADY   = 1'b1;
    assign w_unused = ^PWDATA;
    assign w_rd     = PSEL & PENABLE & ~PWRITE;
    assign w_wr     = PSEL & PENABLE & PWRITE;

    irq_prio_enc #(
        .NUM_SRC  (NUM_SRC),
        .ID_WIDTH (ID_WIDTH)
    ) u_prio_enc (
        .i_req   (r_pending & r_enable),
        .o_valid (w_cand_vld),
        .o_id    (w_cand_id)
    );

    assign w_claim    = w_rd && (PADDR == ADDR_CLAIM) && !r_busy && w_cand_vld;
    assign w_complete = w_wr && (PADDR == ADDR_CLAIM) && r_busy
                        && (PWDATA[ID_WIDTH-1:0] == r_active_id);

    // Edge sources: a new edge beats a simultaneous claim clear.
    assign w_edge      = r_s1 & ~r_s1_d;
    assign w_claim_clr = w_claim ? (NUM_SRC'(1) << (w_cand_id - ID_WIDTH'(1))) : '0;
    assign w_pend_next = (~r_type & r_s1) | (r_type & (w_edge | (r_pending & ~w_claim_clr)));

    assign irq_o = ~r_busy & w_cand_vld;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_s1        <= '0;
            r_s1_d      <= '0;
            r_pending   <= '0;
            r_enable    <= '0;
            r_type      <= '0;
            r_busy      <= 1'b0;
            r_active_id <= ID_WIDTH'(ID_NONE);
        end else begin
            r_s1      <= w_s1_in;
            r_s1_d    <= r_s1;
            r_pending <= w_pend_next;
            if (w_wr && (PADDR == ADDR_ENABLE)) r_enable <= PWDATA[NUM_SRC-1:0];
            if (w_wr && (PADDR == ADDR_TYPE))   r_type   <= PWDATA[NUM_SRC-1:0];
            if (w_claim) begin
                r_busy      <= 1'b1;
                r_active_id <= w_cand_id;
            end else if (w_complete) begin
                r_busy      <= 1'b0;
                r_active_id <= ID_WIDTH'(ID_NONE);
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (w_rd) begin
            case (PADDR)
                ADDR_PENDING: PRDATA = DATA_WIDTH'(r_pending);
                ADDR_ENABLE:  PRDATA = DATA_WIDTH'(r_enable);
                ADDR_TYPE:    PRDATA = DATA_WIDTH'(r_type);
                ADDR_CLAIM:   if (w_claim) PRDATA = DATA_WIDTH'(w_cand_id);
                ADDR_ACTIVE: begin
                    PRDATA = DATA_WIDTH'(r_active_id);
                    PRDATA[ACTIVE_BUSY_BIT] = r_busy;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Self-checking bench for apb_irq_ctrl: vector table, directed corner sequences
// and randomized traffic against a behavioural model of the controller.
module tb_apb_irq_ctrl;

    localparam int NSRC = 8;
`ifdef IRQC_SYNC_EN
    localparam int XLAT = 2;
`else
    localparam int XLAT = 0;
`endif
    localparam int LAT = 2 + XLAT;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic [NSRC-1:0] irq_src;
    logic        irq_o;

    apb_irq_ctrl #(.DATA_WIDTH(32), .NUM_SRC(NSRC), .ID_WIDTH(5)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .irq_src (irq_src),
        .irq_o   (irq_o)
    );

    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_err = 0;
    logic last_irq;

    // Behavioural model state
    bit [NSRC-1:0] m_y0, m_y1, m_s1, m_s1d, m_pend, m_en, m_type;
    bit            m_busy;
    int            m_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_cand();
        for (int i = 0; i < NSRC; i++)
            if (m_pend[i] && m_en[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_y0 = '0; m_y1 = '0; m_s1 = '0; m_s1d = '0;
        m_pend = '0; m_en = '0; m_type = '0; m_busy = 0; m_id = 0;
    endtask

    task automatic model_step(input bit acc, input bit wr, input logic [4:0] addr,
                              input logic [31:0] wd, input logic [NSRC-1:0] src);
        int c;
        bit claim, compl;
        bit [NSRC-1:0] edges, np;
        c     = first_cand();
        claim = acc && !wr && addr == 5'h0C && !m_busy && c >= 0;
        compl = acc && wr && addr == 5'h0C && m_busy && int'(wd[4:0]) == m_id;
        edges = m_s1 & ~m_s1d;
        for (int i = 0; i < NSRC; i++) begin
            if (!m_type[i])              np[i] = m_s1[i];
            else if (edges[i])           np[i] = 1'b1;
            else if (claim && i == c)    np[i] = 1'b0;
            else                         np[i] = m_pend[i];
        end
        m_pend = np;
        if (claim) begin m_busy = 1; m_id = c + 1; end
        if (compl) begin m_busy = 0; m_id = 0; end
        if (acc && wr && addr == 5'h04) m_en   = wd[NSRC-1:0];
        if (acc && wr && addr == 5'h08) m_type = wd[NSRC-1:0];
        m_s1d = m_s1;
`ifdef IRQC_SYNC_EN
        m_s1 = m_y1;
        m_y1 = m_y0;
        m_y0 = src;
`else
        m_s1 = src;
`endif
    endtask

    // One clock: drive, check outputs at negedge against the model, advance.
    task automatic tick(input bit sel, input bit en, input bit wr, input logic [4:0] addr,
                        input logic [31:0] wd, input logic [NSRC-1:0] src,
                        output logic [31:0] rd);
        logic [31:0] exp_rd;
        bit exp_irq, acc;
        int c;
        PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = addr; PWDATA = wd; irq_src = src;
        @(negedge PCLK);
        acc = sel && en;
        c = first_cand();
        exp_irq = !m_busy && c >= 0;
        exp_rd = 0;
        if (acc && !wr) begin
            case (addr)
                5'h00: exp_rd = 32'(m_pend);
                5'h04: exp_rd = 32'(m_en);
                5'h08: exp_rd = 32'(m_type);
                5'h0C: exp_rd = (!m_busy && c >= 0) ? 32'(c + 1) : 32'd0;
                5'h10: exp_rd = (m_busy ? 32'h100 : 32'h0) | 32'(m_id);
                default: exp_rd = 0;
            endcase
        end
        check("model_prdata", PRDATA, exp_rd);
        check("model_irq_o", 32'(irq_o), 32'(exp_irq));
        rd = PRDATA;
        last_irq = irq_o;
        @(posedge PCLK);
        model_step(acc, wr, addr, wd, src);
        #1;
    endtask

    task automatic idle(input logic [NSRC-1:0] src);
        logic [31:0] d;
        tick(0, 0, 0, 5'h00, 32'h0, src, d);
    endtask

    task automatic apb(input bit wr, input logic [4:0] addr, input logic [31:0] wd,
                       input logic [NSRC-1:0] src, output logic [31:0] rd);
        logic [31:0] d;
        tick(1, 0, wr, addr, wd, src, d);
        tick(1, 1, wr, addr, wd, src, rd);
    endtask

    task automatic do_reset();
        PRESETn = 1'b0;
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; irq_src = 0;
        model_reset();
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
    endtask

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic [7:0]  src;
        logic [31:0] exp_rd;
        bit          exp_irq;
        bit          settle;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [31:0] rd;
        logic [NSRC-1:0] cur_src;
        int lat;

        // Vector table: level source 0 through claim/complete and map checks
        tbl.push_back('{0, 5'h04, 32'h0,        8'h00, 32'h0,   0, 0});
        tbl.push_back('{1, 5'h04, 32'h1,        8'h00, 32'h0,   0, 0});
        tbl.push_back('{1, 5'h08, 32'h0,        8'h00, 32'h0,   0, 0});
        tbl.push_back('{0, 5'h00, 32'h0,        8'h01, 32'h0,   0, 0});
        tbl.push_back('{0, 5'h00, 32'h0,        8'h01, 32'h1,   1, 1});
        tbl.push_back('{0, 5'h0C, 32'h0,        8'h01, 32'h1,   1, 0});
        tbl.push_back('{0, 5'h10, 32'h0,        8'h01, 32'h101, 0, 0});
        tbl.push_back('{0, 5'h0C, 32'h0,        8'h01, 32'h0,   0, 0});
        tbl.push_back('{1, 5'h0C, 32'h4,        8'h01, 32'h0,   0, 0});
        tbl.push_back('{0, 5'h10, 32'h0,        8'h01, 32'h101, 0, 0});
        tbl.push_back('{1, 5'h0C, 32'h1,        8'h01, 32'h0,   0, 0});
        tbl.push_back('{0, 5'h10, 32'h0,        8'h01, 32'h0,   1, 0});
        tbl.push_back('{1, 5'h04, 32'h0,        8'h01, 32'h0,   1, 0});
        tbl.push_back('{0, 5'h00, 32'h0,        8'h01, 32'h1,   0, 0});
        tbl.push_back('{0, 5'h0C, 32'h0,        8'h01, 32'h0,   0, 0});
        tbl.push_back('{0, 5'h10, 32'h0,        8'h01, 32'h0,   0, 0});
        tbl.push_back('{0, 5'h14, 32'h0,        8'h01, 32'h0,   0, 0});
        tbl.push_back('{1, 5'h14, 32'hFF,       8'h01, 32'h0,   0, 0});
        tbl.push_back('{0, 5'h04, 32'h0,        8'h01, 32'h0,   0, 0});
        tbl.push_back('{0, 5'h08, 32'h0,        8'h01, 32'h0,   0, 0});
        tbl.push_back('{0, 5'h00, 32'h0,        8'h00, 32'h1,   0, 0});
        tbl.push_back('{0, 5'h00, 32'h0,        8'h00, 32'h0,   0, 1});
        tbl.push_back('{1, 5'h04, 32'hFFFFFFFF, 8'h00, 32'h0,   0, 0});
        tbl.push_back('{0, 5'h04, 32'h0,        8'h00, 32'hFF,  0, 0});
        tbl.push_back('{1, 5'h04, 32'h0,        8'h00, 32'h0,   0, 0});

        // Reset state
        do_reset();
        check("pready", 32'(PREADY), 32'h1);
        check("rst_irq_o", 32'(irq_o), 32'h0);
        apb(0, 5'h00, 0, 0, rd); check("rst_pending", rd, 32'h0);
        apb(0, 5'h08, 0, 0, rd); check("rst_type", rd, 32'h0);
        apb(0, 5'h10, 0, 0, rd); check("rst_active", rd, 32'h0);

        // Table
        foreach (tbl[k]) begin
            if (tbl[k].settle)
                for (int s = 0; s < XLAT; s++) idle(tbl[k].src);
            apb(tbl[k].wr, tbl[k].addr, tbl[k].wd, tbl[k].src, rd);
            check($sformatf("tbl%0d_prdata", k), rd, tbl[k].exp_rd);
            check($sformatf("tbl%0d_irq", k), 32'(last_irq), 32'(tbl[k].exp_irq));
        end

        // Two edge sources arbitrated by lowest index
        do_reset();
        apb(1, 5'h08, 32'h24, 0, rd);
        apb(1, 5'h04, 32'h24, 0, rd);
        apb(1, 5'h14, 32'h0, 8'h24, rd);
        for (int s = 0; s < XLAT; s++) idle(0);
        apb(0, 5'h00, 0, 0, rd);       check("edge_pending", rd, 32'h24);
        apb(0, 5'h0C, 0, 0, rd);       check("edge_claim1", rd, 32'h3);
        check("edge_claim1_irq", 32'(last_irq), 32'h1);
        apb(1, 5'h0C, 32'h3, 0, rd);
        apb(0, 5'h0C, 0, 0, rd);       check("edge_claim2", rd, 32'h6);
        apb(1, 5'h0C, 32'h6, 0, rd);
        apb(0, 5'h00, 0, 0, rd);       check("edge_pending_after", rd, 32'h0);
        check("edge_irq_after", 32'(last_irq), 32'h0);

        // New edge on source 1 in the same cycle it is claimed
        do_reset();
        apb(1, 5'h08, 32'h02, 0, rd);
        apb(1, 5'h04, 32'h02, 0, rd);
        apb(1, 5'h14, 32'h0, 8'h02, rd);
        for (int s = 0; s < XLAT + 2; s++) idle(0);
        apb(0, 5'h00, 0, 0, rd);       check("same_pending_pre", rd, 32'h2);
        for (int s = 0; s < XLAT; s++) idle(8'h02);
        apb(0, 5'h0C, 0, 8'h02, rd);   check("same_claim", rd, 32'h2);
        apb(0, 5'h00, 0, 0, rd);       check("same_pending_kept", rd, 32'h2);
        apb(1, 5'h0C, 32'h2, 0, rd);
        apb(0, 5'h10, 0, 0, rd);       check("same_active_done", rd, 32'h0);

        // Input-to-irq latency, then asynchronous reset drop
        do_reset();
        apb(1, 5'h04, 32'h1, 0, rd);
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            idle(8'h01);
            if (last_irq) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, LAT);
        #2 PRESETn = 1'b0;
        #1 check("async_rst_irq", 32'(irq_o), 32'h0);
        do_reset();

        // Reset while busy
        apb(1, 5'h04, 32'h1, 0, rd);
        for (int s = 0; s < LAT; s++) idle(8'h01);
        apb(0, 5'h0C, 0, 8'h01, rd);   check("busy_claim", rd, 32'h1);
        apb(0, 5'h10, 0, 8'h01, rd);   check("busy_active", rd, 32'h101);
        do_reset();
        apb(0, 5'h10, 0, 0, rd);       check("post_rst_active", rd, 32'h0);
        apb(0, 5'h00, 0, 0, rd);       check("post_rst_pending", rd, 32'h0);
        apb(0, 5'h04, 0, 0, rd);       check("post_rst_enable", rd, 32'h0);
        check("post_rst_irq", 32'(last_irq), 32'h0);

        // Randomized traffic against the model
        cur_src = 0;
        for (int n = 0; n < 400; n++) begin
            int op;
            logic [31:0] wd;
            if ($urandom_range(0, 3) == 0) cur_src = NSRC'($urandom);
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3, 4: apb(0, 5'($urandom_range(0, 7) * 4), 0, cur_src, rd);
                5: apb(1, 5'h04, $urandom, cur_src, rd);
                6: apb(1, 5'h08, $urandom, cur_src, rd);
                7: begin
                    wd = ($urandom_range(0, 1) == 0) ? 32'(m_id) : 32'($urandom_range(0, 31));
                    apb(1, 5'h0C, wd, cur_src, rd);
                end
                8: idle(cur_src);
                default: apb(1, 5'($urandom_range(0, 7) * 4), $urandom, cur_src, rd);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
